// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types: occupancy encoding for the skid-buffered stage and
// the EX/MEM control and data bundles whose widths size the stage payload.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  // Control bundle: every bit here must read as zero on a bubble.
  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] bhw;
    logic       regWrite;
    logic [1:0] memToReg;
    logic [4:0] writeReg;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] aluResult;
    logic        zero;
    logic        overflow;
  } ex_mem_data_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline stage: main register plus one skid entry behind a registered
// in_ready, synchronous flush, and a count of downstream stall cycles.
module ex_mem_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = $bits(ex_mem_ctrl_t),
  parameter int DATA_W = $bits(ex_mem_data_t),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and in_ready comes only from flops.
  pipe_state_e       pipeState;
  pipe_state_e       nextState;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;
  logic              inReadyQ;
  logic              accept;
  logic              consume;
  logic              loadMainIn;
  logic              loadMainSkid;
  logic              loadSkid;

  assign in_ready  = inReadyQ;
  assign out_valid = (pipeState != PIPE_EMPTY);
  assign out_ctrl  = out_valid ? mainCtrl : '0;
  assign out_data  = mainData;
  assign accept    = in_valid & inReadyQ;
  assign consume   = out_valid & out_ready;

  always_comb begin
    nextState    = pipeState;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    case (pipeState)
      PIPE_EMPTY: begin
        if (accept) begin
          loadMainIn = 1'b1;
          nextState  = PIPE_ONE;
        end
      end
      PIPE_ONE: begin
        if (accept && consume) begin
          loadMainIn = 1'b1;
        end else if (accept) begin
          loadSkid  = 1'b1;
          nextState = PIPE_FULL;
        end else if (consume) begin
          nextState = PIPE_EMPTY;
        end
      end
      PIPE_FULL: begin
        if (consume) begin
          loadMainSkid = 1'b1;
          nextState    = PIPE_ONE;
        end
      end
      default: nextState = PIPE_EMPTY;
    endcase
    // Flush drops anything accepted this cycle and leaves data untouched.
    if (flush) begin
      nextState    = PIPE_EMPTY;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipeState <= PIPE_EMPTY;
      inReadyQ  <= 1'b0;
      mainCtrl  <= '0;
      mainData  <= '0;
      skidCtrl  <= '0;
      skidData  <= '0;
    end else begin
      pipeState <= nextState;
      inReadyQ  <= (nextState != PIPE_FULL);
      if (flush) begin
        mainCtrl <= '0;
        skidCtrl <= '0;
      end else begin
        if (loadMainIn) begin
          mainCtrl <= in_ctrl;
          mainData <= in_data;
        end else if (loadMainSkid) begin
          mainCtrl <= skidCtrl;
          mainData <= skidData;
        end
        if (loadSkid) begin
          skidCtrl <= in_ctrl;
          skidData <= in_data;
        end
      end
    end
  end

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage: streaming, skid stall, counter
// saturation, flush corner cases and mid-stream reset.
module tb_ex_mem_pipe_stage;
  import mips_pipe_pkg::*;

  localparam int CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int DATA_W = $bits(ex_mem_data_t);
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  int total;
  int bad;

  ex_mem_pipe_stage #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle before checking or driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input int val);
    in_valid = v;
    in_ctrl  = CTRL_W'(val);
    in_data  = DATA_W'(val);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset state
    step();
    step();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    chk("post_rst_out_valid", 128'(out_valid), 128'(0));

    // streaming 1..8 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, i);
      step();
      chk($sformatf("stream_valid_%0d", i), 128'(out_valid), 128'(1));
      chk($sformatf("stream_ctrl_%0d", i), 128'(out_ctrl), 128'(i));
      chk($sformatf("stream_data_%0d", i), 128'(out_data), 128'(i));
      chk($sformatf("stream_ready_%0d", i), 128'(in_ready), 128'(1));
    end
    offer(1'b0, 0);
    step();
    chk("stream_drain_valid", 128'(out_valid), 128'(0));
    chk("stream_drain_ctrl", 128'(out_ctrl), 128'(0));
    chk("stream_drain_data", 128'(out_data), 128'(8));
    chk("stream_stall_cnt", 128'(stall_cnt), 128'(0));

    // skid: A=5 into main, B=6 into skid while stalled
    out_ready = 1'b0;
    offer(1'b1, 5);
    step();
    chk("skid_a_ctrl", 128'(out_ctrl), 128'(5));
    chk("skid_a_ready", 128'(in_ready), 128'(1));
    offer(1'b1, 6);
    step();
    chk("skid_full_ready", 128'(in_ready), 128'(0));
    chk("skid_full_ctrl", 128'(out_ctrl), 128'(5));
    chk("skid_full_stall", 128'(stall_cnt), 128'(1));
    offer(1'b0, 0);
    step();
    chk("skid_hold_ctrl", 128'(out_ctrl), 128'(5));
    chk("skid_hold_stall", 128'(stall_cnt), 128'(2));
    out_ready = 1'b1;
    step();
    chk("skid_b_valid", 128'(out_valid), 128'(1));
    chk("skid_b_ctrl", 128'(out_ctrl), 128'(6));
    chk("skid_b_data", 128'(out_data), 128'(6));
    chk("skid_b_ready", 128'(in_ready), 128'(1));
    step();
    chk("skid_empty_valid", 128'(out_valid), 128'(0));
    chk("skid_stall_cnt", 128'(stall_cnt), 128'(2));

    // counter saturation: 2^4+3 stalled cycles
    out_ready = 1'b0;
    offer(1'b1, 9);
    step();
    offer(1'b0, 0);
    for (int i = 0; i < 19; i++) step();
    chk("sat_stall_cnt", 128'(stall_cnt), 128'(15));
    chk("sat_hold_ctrl", 128'(out_ctrl), 128'(9));

    // flush while FULL
    offer(1'b1, 10);
    step();
    chk("flush_pre_ready", 128'(in_ready), 128'(0));
    offer(1'b0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));
    chk("flush_data_kept", 128'(out_data), 128'(9));
    chk("flush_stall_kept", 128'(stall_cnt), 128'(15));
    out_ready = 1'b1;
    offer(1'b1, 11);
    step();
    chk("flush_next_valid", 128'(out_valid), 128'(1));
    chk("flush_next_ctrl", 128'(out_ctrl), 128'(11));
    chk("flush_next_data", 128'(out_data), 128'(11));
    offer(1'b0, 0);
    step();
    chk("flush_next_drain", 128'(out_valid), 128'(0));

    // accept + consume + flush in ONE
    out_ready = 1'b0;
    offer(1'b1, 12);
    step();
    offer(1'b1, 13);
    out_ready = 1'b1;
    flush     = 1'b1;
    chk("acf_delivered_valid", 128'(out_valid), 128'(1));
    chk("acf_delivered_ctrl", 128'(out_ctrl), 128'(12));
    step();
    flush = 1'b0;
    offer(1'b0, 0);
    chk("acf_valid", 128'(out_valid), 128'(0));
    chk("acf_ctrl", 128'(out_ctrl), 128'(0));
    chk("acf_ready", 128'(in_ready), 128'(1));
    chk("acf_data_kept", 128'(out_data), 128'(12));
    step();
    chk("acf_dropped", 128'(out_valid), 128'(0));

    // reset mid-stream while FULL, with flush also high
    out_ready = 1'b0;
    offer(1'b1, 14);
    step();
    offer(1'b1, 15);
    step();
    chk("mrst_pre_ready", 128'(in_ready), 128'(0));
    rst   = 1'b1;
    flush = 1'b1;
    offer(1'b1, 16);
    step();
    chk("mrst_valid", 128'(out_valid), 128'(0));
    chk("mrst_ready", 128'(in_ready), 128'(0));
    chk("mrst_ctrl", 128'(out_ctrl), 128'(0));
    chk("mrst_data", 128'(out_data), 128'(0));
    chk("mrst_stall", 128'(stall_cnt), 128'(0));
    rst   = 1'b0;
    flush = 1'b0;
    offer(1'b0, 0);
    step();
    chk("mrst_after_ready", 128'(in_ready), 128'(1));
    chk("mrst_after_valid", 128'(out_valid), 128'(0));
    out_ready = 1'b1;
    offer(1'b1, 12'h3a5);
    step();
    chk("mrst_next_ctrl", 128'(out_ctrl), 128'(12'h3a5));
    chk("mrst_next_data", 128'(out_data), 128'(12'h3a5));
    offer(1'b0, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
